counter_report_tx: RTL and testbench
====================================

// Module: counter_report_tx
// PURPOSE
//  Reverse path of the UART counter control: formats a snapshot of the up/down counter
//  (value, direction, run/stop) as ASCII text and streams it byte-by-byte into top_uart_tx.
//  Sits beside counter_cu in top_counter_up_down; it owns start_trigger/tx_data whenever a
//  report is in flight. Frame is "<D><S>:<d3><d2><d1><d0>\r\n" (9 bytes).
// PARAMETERS
//  PERIOD_CLKS  100_000_000  clocks between automatic reports when auto_en=1 (1 s @ 100 MHz)
//  MAX_COUNT    9999         largest printable value; larger inputs saturate to it
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous active-low reset
//  count          in   14  counter value (binary)
//  mode           in   1   0=up, 1=down
//  en             in   1   1=running, 0=stopped
//  req            in   1   one-cycle report request (e.g. rx 'Q' decoded by counter_cu)
//  auto_en        in   1   enables periodic reports every PERIOD_CLKS
//  tx_busy        in   1   from top_uart_tx: transmitter occupied
//  tx_done        in   1   from top_uart_tx: one-cycle pulse, current byte finished
//  start_trigger  out  1   one-cycle pulse: load tx_data into top_uart_tx
//  tx_data        out  8   byte to transmit
//  busy           out  1   high from snapshot until last byte's tx_done
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, start_trigger=0, tx_data=8'h00, busy=0, pending=0, period cnt=0.
//  Trigger: req=1, or period counter reaching PERIOD_CLKS-1 while auto_en=1 (counter then wraps to 0;
//   held at 0 while auto_en=0). Trigger in IDLE -> snapshot count/mode/en that same edge.
//  Trigger while busy -> pending=1 (one deep, further triggers merge); serviced right after
//   the final tx_done, with a fresh snapshot taken then. Trigger on the same cycle as final tx_done counts as pending.
//  Saturation: snapshot value = (count > MAX_COUNT) ? MAX_COUNT : count.
//  FSM: IDLE -> CONV (bcd_conv_seq, fixed 14 cycles shift-add-3) -> LOAD (select byte idx) ->
//   START (pulse start_trigger only in a cycle with tx_busy=0; else wait) -> WAIT (until tx_done)
//   -> LOAD if idx<8 (idx++), else IDLE (or CONV directly if pending, clearing pending).
//  Byte order: idx0 mode ? "D"(8'h44) : "U"(8'h55); idx1 en ? "R"(8'h52) : "S"(8'h53);
//   idx2 ":"(8'h3A); idx3..6 thousands..units as 8'h30+digit, leading zeros kept; idx7 8'h0D; idx8 8'h0A.
//  tx_data registered; valid in LOAD and held stable through WAIT until tx_done.
//  Latency: trigger in IDLE -> first start_trigger no earlier than 16 clocks (1 snapshot + 14 conv + 1 load).
//  start_trigger never asserted while tx_busy=1; never twice for one byte.
//  Mid-frame changes of count/mode/en do not affect the frame in progress.
//  Reset mid-frame: frame abandoned immediately, no further bytes; next trigger gives a full frame.
// STRUCTURE
//  Package counter_uart_pkg: ASCII constants (U,D,R,S,colon,CR,LF,'0'), FRAME_LEN=9,
//   state encoding localparams, shared with counter_cu command codes (R,S,C,M,Q).
//  Sub-module bcd_conv_seq: start/done handshake, 14-bit binary -> 4x4-bit BCD, 14-cycle double dabble.
//  Top level: trigger/pending logic, period counter, byte mux, TX FSM.
// TESTING (tx_busy/tx_done from a model that holds busy 10 clks per byte; PERIOD_CLKS=1000)
//  1 count=1234,mode=0,en=1,req pulse -> bytes 55 52 3A 31 32 33 34 0D 0A, busy falls after 9th tx_done.
//  2 count=0,mode=1,en=0 -> 44 53 3A 30 30 30 30 0D 0A; count=12000 -> digits 39 39 39 39.
//  3 req at byte 3 with count changed 1234->42 mid-frame -> frame 1 unchanged; frame 2 digits 30 30 34 32 follows back-to-back.
//  4 tx_busy forced high 50 clks at START -> start_trigger stays 0, pulses exactly once after busy drops.
//  5 auto_en=1, no req -> frame starts every 1000 clks; auto_en=0 -> none.
//  6 rst low during byte 5 -> start_trigger=0, busy=0, tx_data=00 at once; next req -> complete 9-byte frame.

Source files
------------

// File: rtl/counter_uart_pkg.sv
// ---------------------------------------------------------------------------
// counter_uart_pkg
//   Shared constants for the UART control path of the up/down counter:
//   ASCII characters used in the status report frame, the frame length,
//   the report transmitter FSM encoding, the command codes decoded by
//   counter_cu, and the byte-select helper that builds the report frame.
// ---------------------------------------------------------------------------
package counter_uart_pkg;

  // Report frame characters
  localparam logic [7:0] ASCII_U     = 8'h55;
  localparam logic [7:0] ASCII_D     = 8'h44;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;

  // "<D><S>:<d3><d2><d1><d0>\r\n"
  localparam int         FRAME_LEN   = 9;

  // Command codes received by counter_cu
  localparam logic [7:0] CMD_RUN     = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STOP    = 8'h53;  // 'S'
  localparam logic [7:0] CMD_CLEAR   = 8'h43;  // 'C'
  localparam logic [7:0] CMD_MODE    = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_QUERY   = 8'h51;  // 'Q'

  // Report transmitter FSM encoding
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CONV  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } tx_state_e;

  // Byte at position idx of the report frame; digits come from a packed
  // 4-digit BCD word, thousands in the top nibble, leading zeros kept.
  function automatic logic [7:0] frame_byte(
    input logic [3:0]  idx,
    input logic        mode,
    input logic        en,
    input logic [15:0] bcd
  );
    logic [7:0] b;
    case (idx)
      4'd0:    b = mode ? ASCII_D : ASCII_U;
      4'd1:    b = en ? ASCII_R : ASCII_S;
      4'd2:    b = ASCII_COLON;
      4'd3:    b = ASCII_0 + {4'h0, bcd[15:12]};
      4'd4:    b = ASCII_0 + {4'h0, bcd[11:8]};
      4'd5:    b = ASCII_0 + {4'h0, bcd[7:4]};
      4'd6:    b = ASCII_0 + {4'h0, bcd[3:0]};
      4'd7:    b = ASCII_CR;
      4'd8:    b = ASCII_LF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/counter_report_tx_if.sv
// ---------------------------------------------------------------------------
// counter_report_tx_if
//   Byte handshake between the report formatter and top_uart_tx.
//     start_trigger  formatter -> uart  one-cycle pulse, load tx_data
//     tx_data        formatter -> uart  byte to send
//     tx_busy        uart -> formatter  transmitter occupied
//     tx_done        uart -> formatter  one-cycle pulse, byte finished
//   master: report formatter side, slave: UART transmitter side.
// ---------------------------------------------------------------------------
interface counter_report_tx_if;
  logic       start_trigger;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output start_trigger,
    output tx_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  start_trigger,
    input  tx_data,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/bcd_conv_seq.sv
// ---------------------------------------------------------------------------
// bcd_conv_seq
//   Sequential 14-bit binary to 4-digit BCD converter (double dabble).
//   A start pulse while idle latches bin; exactly 14 add-3/shift steps
//   follow, then done pulses for one cycle. bcd holds the result until
//   the next start. Inputs above 9999 overflow the thousands digit, so the
//   caller saturates beforehand.
//   Ports:
//     clk    in   system clock
//     rst    in   asynchronous active-low reset
//     start  in   one-cycle conversion request (ignored while converting)
//     bin    in   14-bit binary value
//     done   out  one-cycle pulse, bcd valid
//     bcd    out  {thousands, hundreds, tens, units}
// ---------------------------------------------------------------------------
module bcd_conv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        done,
  output logic [15:0] bcd
);

  localparam logic [3:0] LAST_STEP = 4'd13;

  logic        busy_r;
  logic [3:0]  step_r;
  logic [13:0] bin_r;
  logic [15:0] bcd_r;
  logic        done_r;
  logic [15:0] adj_s;

  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Add-3 correction of every digit ahead of the next shift
  always_comb begin
    adj_s = {add3(bcd_r[15:12]), add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};
  end

  // Conversion sequencer: latch, 14 shift steps, done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= 1'b0;
      step_r <= 4'd0;
      bin_r  <= 14'd0;
      bcd_r  <= 16'd0;
      done_r <= 1'b0;
    end else if (busy_r) begin
      // Shift the corrected BCD digits and the binary together by one bit
      {bcd_r, bin_r} <= {adj_s, bin_r} << 5'd1;
      if (step_r == LAST_STEP) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
        step_r <= 4'd0;
      end else begin
        step_r <= step_r + 4'd1;
        done_r <= 1'b0;
      end
    end else if (start) begin
      busy_r <= 1'b1;
      step_r <= 4'd0;
      bin_r  <= bin;
      bcd_r  <= 16'd0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done = done_r;
  assign bcd  = bcd_r;

endmodule

// File: rtl/counter_report_tx.sv
// ---------------------------------------------------------------------------
// counter_report_tx
//   Formats a snapshot of the up/down counter as "<D><S>:<d3><d2><d1><d0>\r\n"
//   and streams it byte by byte into top_uart_tx. A report is triggered by
//   req or, with auto_en set, every PERIOD_CLKS clocks. A trigger arriving
//   while a report is in flight is remembered (one deep) and serviced with a
//   fresh snapshot right after the final byte completes.
//   Ports:
//     clk      in   system clock
//     rst      in   asynchronous active-low reset
//     count    in   counter value (binary, saturated to MAX_COUNT)
//     mode     in   0 = up, 1 = down
//     en       in   1 = running, 0 = stopped
//     req      in   one-cycle report request
//     auto_en  in   enables periodic reports
//     uart     master side of the byte handshake to top_uart_tx
//     busy     out  high from snapshot until the last byte's tx_done
// ---------------------------------------------------------------------------
module counter_report_tx
  import counter_uart_pkg::*;
#(
  parameter int PERIOD_CLKS = 100_000_000,
  parameter int MAX_COUNT   = 9999
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [13:0]         count,
  input  logic                mode,
  input  logic                en,
  input  logic                req,
  input  logic                auto_en,
  counter_report_tx_if.master uart,
  output logic                busy
);

  localparam int            PW          = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CLKS - 1);
  localparam logic [13:0]   MAX_VAL     = 14'(MAX_COUNT);
  localparam logic [3:0]    LAST_IDX    = 4'(FRAME_LEN - 1);

  tx_state_e     state_r, state_s;
  logic [3:0]    idx_r, idx_s;
  logic [7:0]    tx_data_r, tx_data_s;
  logic          start_trigger_r, start_trigger_s;
  logic          busy_r, busy_s;
  logic          pending_r, pending_s;
  logic          conv_start_r, conv_start_s;
  logic [13:0]   snap_val_r, snap_val_s;
  logic          snap_mode_r, snap_mode_s;
  logic          snap_en_r, snap_en_s;
  logic [PW-1:0] period_cnt_r, period_cnt_s;
  logic          period_hit_s;
  logic          trigger_s;
  logic          conv_done_s;
  logic [15:0]   bcd_s;

  bcd_conv_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start_r),
    .bin   (snap_val_r),
    .done  (conv_done_s),
    .bcd   (bcd_s)
  );

  // Periodic trigger: counts only while auto_en, wraps on the hit cycle
  always_comb begin
    if (!auto_en) begin
      period_cnt_s = {PW{1'b0}};
      period_hit_s = 1'b0;
    end else if (period_cnt_r == PERIOD_LAST) begin
      period_cnt_s = {PW{1'b0}};
      period_hit_s = 1'b1;
    end else begin
      period_cnt_s = period_cnt_r + PW'(1);
      period_hit_s = 1'b0;
    end
  end

  assign trigger_s = req | period_hit_s;

  // TX FSM next state, snapshot, pending flag and byte mux
  always_comb begin
    state_s         = state_r;
    idx_s           = idx_r;
    tx_data_s       = tx_data_r;
    start_trigger_s = 1'b0;
    busy_s          = busy_r;
    conv_start_s    = 1'b0;
    snap_val_s      = snap_val_r;
    snap_mode_s     = snap_mode_r;
    snap_en_s       = snap_en_r;

    // Any trigger outside IDLE merges into the single pending slot
    if (trigger_s && (state_r != ST_IDLE)) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (trigger_s) begin
          snap_val_s   = (count > MAX_VAL) ? MAX_VAL : count;
          snap_mode_s  = mode;
          snap_en_s    = en;
          conv_start_s = 1'b1;
          busy_s       = 1'b1;
          state_s      = ST_CONV;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CONV: begin
        // Digits are valid in the cycle done pulses, so byte 0 loads now
        if (conv_done_s) begin
          idx_s     = 4'd0;
          tx_data_s = frame_byte(4'd0, snap_mode_r, snap_en_r, bcd_s);
          state_s   = ST_LOAD;
        end else begin
          state_s = ST_CONV;
        end
      end

      ST_LOAD: begin
        state_s = ST_START;
      end

      ST_START: begin
        if (!uart.tx_busy) begin
          start_trigger_s = 1'b1;
          state_s         = ST_WAIT;
        end else begin
          state_s = ST_START;
        end
      end

      ST_WAIT: begin
        if (uart.tx_done) begin
          if (idx_r < LAST_IDX) begin
            idx_s     = idx_r + 4'd1;
            tx_data_s = frame_byte(idx_r + 4'd1, snap_mode_r, snap_en_r, bcd_s);
            state_s   = ST_LOAD;
          end else if (pending_r || trigger_s) begin
            // Back-to-back report with a fresh snapshot; busy stays high
            snap_val_s   = (count > MAX_VAL) ? MAX_VAL : count;
            snap_mode_s  = mode;
            snap_en_s    = en;
            conv_start_s = 1'b1;
            pending_s    = 1'b0;
            state_s      = ST_CONV;
          end else begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end

      default: begin
        busy_s    = 1'b0;
        pending_s = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= ST_IDLE;
      idx_r           <= 4'd0;
      tx_data_r       <= 8'h00;
      start_trigger_r <= 1'b0;
      busy_r          <= 1'b0;
      pending_r       <= 1'b0;
      conv_start_r    <= 1'b0;
      snap_val_r      <= 14'd0;
      snap_mode_r     <= 1'b0;
      snap_en_r       <= 1'b0;
      period_cnt_r    <= {PW{1'b0}};
    end else begin
      state_r         <= state_s;
      idx_r           <= idx_s;
      tx_data_r       <= tx_data_s;
      start_trigger_r <= start_trigger_s;
      busy_r          <= busy_s;
      pending_r       <= pending_s;
      conv_start_r    <= conv_start_s;
      snap_val_r      <= snap_val_s;
      snap_mode_r     <= snap_mode_s;
      snap_en_r       <= snap_en_s;
      period_cnt_r    <= period_cnt_s;
    end
  end

  assign uart.start_trigger = start_trigger_r;
  assign uart.tx_data       = tx_data_r;
  assign busy               = busy_r;

endmodule

// File: tb/tb_counter_report_tx.sv
// ---------------------------------------------------------------------------
// tb_counter_report_tx
//   Directed bench for counter_report_tx with a UART model that holds
//   tx_busy for 10 clocks per byte and pulses tx_done as busy drops.
// ---------------------------------------------------------------------------
module tb_counter_report_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] count;
  logic        mode;
  logic        en;
  logic        req;
  logic        auto_en;
  logic        busy;
  logic        force_busy;

  int checks   = 0;
  int failures = 0;

  // Model / monitor state (written only by the always blocks below)
  int         cyc        = 0;
  int         n_starts   = 0;
  int         viol       = 0;
  int         done_cnt   = 0;
  int         busy_falls = 0;
  logic       prev_busy  = 1'b0;
  logic       m_busy;
  logic       m_done;
  int         m_cnt;
  logic [7:0] log_q[$];
  int         log_cyc_q[$];

  always #5 clk = ~clk;

  counter_report_tx_if uif();

  counter_report_tx #(.PERIOD_CLKS(1000), .MAX_COUNT(9999)) dut (
    .clk     (clk),
    .rst     (rst),
    .count   (count),
    .mode    (mode),
    .en      (en),
    .req     (req),
    .auto_en (auto_en),
    .uart    (uif.master),
    .busy    (busy)
  );

  assign uif.tx_busy = m_busy | force_busy;
  assign uif.tx_done = m_done;

  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: 10 busy clocks per byte, done pulse at the end
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (uif.start_trigger) begin
        n_starts <= n_starts + 1;
        if (uif.tx_busy) begin
          viol <= viol + 1;
        end else begin
          m_busy <= 1'b1;
          m_cnt  <= 0;
          log_q.push_back(uif.tx_data);
          log_cyc_q.push_back(cyc);
        end
      end else if (m_busy) begin
        if (m_cnt == 9) begin
          m_busy   <= 1'b0;
          m_done   <= 1'b1;
          done_cnt <= done_cnt + 1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    prev_busy <= busy;
    if (prev_busy && !busy) busy_falls <= busy_falls + 1;
  end

  task automatic pulse_req(output int rc);
    @(posedge clk);
    #1 req = 1'b1;
    rc = cyc;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int max_cyc, output bit ok);
    int k;
    k = 0;
    while ((log_q.size() < n) && (k < max_cyc)) begin
      @(negedge clk);
      k++;
    end
    ok = (log_q.size() >= n);
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    int k;
    k = 0;
    while ((busy || m_busy) && (k < max_cyc)) begin
      @(negedge clk);
      k++;
    end
    ok = !(busy || m_busy);
  endtask

  task automatic test_reset;
    int base;
    @(negedge clk);
    checks++; if (uif.start_trigger !== 1'b0) begin $display("FAIL reset_start got=%b exp=0", uif.start_trigger); failures++; end
    checks++; if (uif.tx_data !== 8'h00) begin $display("FAIL reset_tx_data got=%h exp=00", uif.tx_data); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); failures++; end
    base = log_q.size();
    @(posedge clk); #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin $display("FAIL idle_busy got=%b exp=0", busy); failures++; end
    checks++; if (log_q.size() !== base) begin $display("FAIL idle_no_bytes got=%0d exp=%0d", log_q.size(), base); failures++; end
  endtask

  task automatic test_basic;
    logic [71:0] exp_f;
    int base, dbase, rc, lat;
    bit ok;
    exp_f = 72'h55523A313233340D0A;
    base  = log_q.size();
    dbase = done_cnt;
    count = 14'd1234; mode = 1'b0; en = 1'b1;
    pulse_req(rc);
    wait_bytes(base + 9, 400, ok);
    checks++;
    if (!ok) begin
      $display("FAIL basic_timeout got=%0d bytes exp=9", log_q.size() - base); failures++;
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (log_q[base+i] !== exp_f[71-8*i -: 8]) begin
          $display("FAIL basic_byte%0d got=%h exp=%h", i, log_q[base+i], exp_f[71-8*i -: 8]); failures++;
        end
      end
      lat = log_cyc_q[base] - rc;
      checks++; if (lat < 16) begin $display("FAIL basic_latency got=%0d exp>=16", lat); failures++; end
      checks++; if (busy !== 1'b1) begin $display("FAIL basic_busy_last_byte got=%b exp=1", busy); failures++; end
      wait_idle(100, ok);
      checks++; if (!ok) begin $display("FAIL basic_idle_timeout got=busy exp=idle"); failures++; end
      checks++; if ((done_cnt - dbase) !== 9) begin $display("FAIL basic_done_at_busy_fall got=%0d exp=9", done_cnt - dbase); failures++; end
    end
  endtask

  task automatic test_digits;
    logic [71:0] exp_f [3];
    logic [13:0] cnt_v [3];
    logic        mode_v [3];
    logic        en_v [3];
    int base, rc;
    bit ok;
    exp_f[0] = 72'h44533A303030300D0A; cnt_v[0] = 14'd0;     mode_v[0] = 1'b1; en_v[0] = 1'b0;
    exp_f[1] = 72'h55523A393939390D0A; cnt_v[1] = 14'd12000; mode_v[1] = 1'b0; en_v[1] = 1'b1;
    exp_f[2] = 72'h44523A393939390D0A; cnt_v[2] = 14'd10000; mode_v[2] = 1'b1; en_v[2] = 1'b1;
    for (int v = 0; v < 3; v++) begin
      base = log_q.size();
      count = cnt_v[v]; mode = mode_v[v]; en = en_v[v];
      pulse_req(rc);
      wait_bytes(base + 9, 400, ok);
      checks++;
      if (!ok) begin
        $display("FAIL digits%0d_timeout got=%0d bytes exp=9", v, log_q.size() - base); failures++;
      end else begin
        for (int i = 0; i < 9; i++) begin
          checks++;
          if (log_q[base+i] !== exp_f[v][71-8*i -: 8]) begin
            $display("FAIL digits%0d_byte%0d got=%h exp=%h", v, i, log_q[base+i], exp_f[v][71-8*i -: 8]); failures++;
          end
        end
      end
      wait_idle(100, ok);
    end
  endtask

  task automatic test_back_to_back;
    logic [71:0] exp_f [2];
    int base, fbase, rc;
    bit ok;
    exp_f[0] = 72'h55523A313233340D0A;
    exp_f[1] = 72'h55523A303034320D0A;
    base  = log_q.size();
    fbase = busy_falls;
    count = 14'd1234; mode = 1'b0; en = 1'b1;
    pulse_req(rc);
    wait_bytes(base + 4, 400, ok);
    count = 14'd42;
    pulse_req(rc);
    wait_bytes(base + 18, 800, ok);
    checks++;
    if (!ok) begin
      $display("FAIL b2b_timeout got=%0d bytes exp=18", log_q.size() - base); failures++;
    end else begin
      for (int i = 0; i < 18; i++) begin
        checks++;
        if (log_q[base+i] !== exp_f[i/9][71-8*(i%9) -: 8]) begin
          $display("FAIL b2b_byte%0d got=%h exp=%h", i, log_q[base+i], exp_f[i/9][71-8*(i%9) -: 8]); failures++;
        end
      end
    end
    wait_idle(100, ok);
    checks++; if ((busy_falls - fbase) !== 1) begin $display("FAIL b2b_busy_falls got=%0d exp=1", busy_falls - fbase); failures++; end
  endtask

  task automatic test_busy_hold;
    logic [71:0] exp_f;
    int base, sbase, vbase, rc, rel;
    bit ok;
    exp_f = 72'h55533A303030370D0A;
    base  = log_q.size();
    sbase = n_starts;
    vbase = viol;
    count = 14'd7; mode = 1'b0; en = 1'b0;
    force_busy = 1'b1;
    pulse_req(rc);
    repeat (68) @(negedge clk);
    checks++; if (n_starts !== sbase) begin $display("FAIL hold_no_start got=%0d exp=0", n_starts - sbase); failures++; end
    force_busy = 1'b0;
    rel = cyc;
    wait_bytes(base + 9, 400, ok);
    checks++;
    if (!ok) begin
      $display("FAIL hold_timeout got=%0d bytes exp=9", log_q.size() - base); failures++;
    end else begin
      checks++; if (log_cyc_q[base] < rel) begin $display("FAIL hold_first_after_release got=%0d exp>=%0d", log_cyc_q[base], rel); failures++; end
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (log_q[base+i] !== exp_f[71-8*i -: 8]) begin
          $display("FAIL hold_byte%0d got=%h exp=%h", i, log_q[base+i], exp_f[71-8*i -: 8]); failures++;
        end
      end
    end
    wait_idle(100, ok);
    checks++; if ((n_starts - sbase) !== 9) begin $display("FAIL hold_start_count got=%0d exp=9", n_starts - sbase); failures++; end
    checks++; if (viol !== vbase) begin $display("FAIL hold_start_while_busy got=%0d exp=0", viol - vbase); failures++; end
  endtask

  task automatic test_auto;
    int base;
    count = 14'd7; mode = 1'b1; en = 1'b1;
    base = log_q.size();
    @(posedge clk); #1 auto_en = 1'b1;
    repeat (2500) @(negedge clk);
    checks++;
    if ((log_q.size() - base) !== 18) begin
      $display("FAIL auto_byte_count got=%0d exp=18", log_q.size() - base); failures++;
    end else begin
      checks++; if ((log_cyc_q[base+9] - log_cyc_q[base]) !== 1000) begin $display("FAIL auto_interval got=%0d exp=1000", log_cyc_q[base+9] - log_cyc_q[base]); failures++; end
      checks++; if (log_q[base] !== 8'h44) begin $display("FAIL auto_f0_byte0 got=%h exp=44", log_q[base]); failures++; end
      checks++; if (log_q[base+15] !== 8'h37) begin $display("FAIL auto_f1_units got=%h exp=37", log_q[base+15]); failures++; end
    end
    @(posedge clk); #1 auto_en = 1'b0;
    base = log_q.size();
    repeat (1500) @(negedge clk);
    checks++; if (log_q.size() !== base) begin $display("FAIL auto_off_bytes got=%0d exp=0", log_q.size() - base); failures++; end
  endtask

  task automatic test_reset_mid;
    logic [71:0] exp_f;
    int base, rc;
    bit ok;
    exp_f = 72'h55533A353637380D0A;
    base  = log_q.size();
    count = 14'd5678; mode = 1'b0; en = 1'b0;
    pulse_req(rc);
    wait_bytes(base + 5, 400, ok);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (uif.start_trigger !== 1'b0) begin $display("FAIL rmid_start got=%b exp=0", uif.start_trigger); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL rmid_busy got=%b exp=0", busy); failures++; end
    checks++; if (uif.tx_data !== 8'h00) begin $display("FAIL rmid_tx_data got=%h exp=00", uif.tx_data); failures++; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (log_q.size() !== (base + 5)) begin $display("FAIL rmid_abandoned got=%0d exp=5", log_q.size() - base); failures++; end
    base = log_q.size();
    pulse_req(rc);
    wait_bytes(base + 9, 400, ok);
    checks++;
    if (!ok) begin
      $display("FAIL rmid_timeout got=%0d bytes exp=9", log_q.size() - base); failures++;
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (log_q[base+i] !== exp_f[71-8*i -: 8]) begin
          $display("FAIL rmid_byte%0d got=%h exp=%h", i, log_q[base+i], exp_f[71-8*i -: 8]); failures++;
        end
      end
    end
    wait_idle(100, ok);
  endtask

  initial begin
    rst        = 1'b0;
    req        = 1'b0;
    count      = 14'd0;
    mode       = 1'b0;
    en         = 1'b0;
    auto_en    = 1'b0;
    force_busy = 1'b0;
    repeat (2) @(posedge clk);
    test_reset;
    test_basic;
    test_digits;
    test_back_to_back;
    test_busy_hold;
    test_auto;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
